rd_data_capture: RTL and testbench
==================================

RD_DATA_CAPTURE -- requirements
Module: rd_data_capture

Interface
REQ-001 Parameter data_size, 32, SDRAM DQ and read-data width.
REQ-002 Parameter burst_size, 4, bur_len width.
REQ-003 Parameter cas_size, 3, cas_lat width.
REQ-004 clk0  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 page_mod  in  1  1 = full-page mode, 0 = fixed-length burst.
REQ-007 do_reada  in  1  one-cycle pulse: read command issued this cycle.
REQ-008 do_writea1, do_preacharge, do_refresh  in  1 each  page-burst terminators.
REQ-009 bur_len  in  burst_size  burst length (1, 2, 4 or 8).
REQ-010 cas_lat  in  cas_size  CAS latency (2 or 3).
REQ-011 sdr_dq_in  in  data_size  raw SDRAM DQ input.
REQ-012 rd_ready  in  1  consumer accepts rd_data.
REQ-013 rd_valid  out  1  rd_data holds a captured read beat.
REQ-014 rd_data  out  data_size  captured read beat.
REQ-015 rd_last  out  1  final beat of a fixed-length burst.
REQ-016 rd_busy  out  1  a read window is open or beats are in flight.
REQ-017 rd_ovf  out  1  sticky: beat dropped for lack of buffer space.

Function
REQ-018 sdr_dq_in shall be registered every cycle, unconditionally.
REQ-019 Issue stage: do_reada with page_mod=0 loads beat counter with bur_len; bur_len not in {1,2,4,8} is treated as 1.
REQ-020 Issue stage emits one expect bit per cycle while counter is nonzero, starting the do_reada cycle (T0); expect is 1 for exactly bur_len cycles.
REQ-021 Expect bits travel a delay line; tap is cas_lat stages for cas_lat=2, 3 stages for any other value.
REQ-022 A beat is captured when the delayed expect bit and the registered DQ align; first beat is visible on rd_valid (no FIFO) at cycle T0+cas_lat+1.
REQ-023 rd_last marks the beat where the counter reached its final count (non-page mode only).
REQ-024 Page mode: do_reada opens the window (expect=1 every cycle); do_preacharge, do_writea1 or do_refresh closes it; beats already in the delay line are still captured.
REQ-025 do_reada while a burst is in flight shall reload the counter (read interrupt); earlier beats already in the delay line are delivered, the old burst gets no rd_last.
REQ-026 Terminator and do_reada in the same cycle: do_reada wins.
REQ-027 cas_lat/bur_len changes take effect at the next do_reada only.
REQ-028 rd_busy = counter nonzero OR page window open OR any delay-line bit set OR (with FIFO) buffer non-empty.

Reset
REQ-029 Reset clears counter, page window, delay line, DQ register, buffer pointers and rd_ovf; rd_valid, rd_last, rd_busy, rd_ovf = 0, rd_data = 0.
REQ-030 Reset mid-burst discards all in-flight beats; no beat shall appear after reset release without a new do_reada.

Configuration
REQ-031 Macro RD_CAPTURE_FIFO_EN defined: captured beats (data plus last flag) enter an 8-entry FIFO; rd_valid = not empty; pop on rd_valid AND rd_ready; simultaneous push and pop when full is legal.
REQ-032 Push when full and no pop shall drop the beat and set rd_ovf.
REQ-033 RD_CAPTURE_FIFO_EN undefined: rd_valid/rd_data/rd_last are the capture register outputs, valid one cycle per beat; rd_ready ignored; rd_ovf tied 0.

Structure
REQ-034 data_size, burst_size, cas_size, FIFO depth 8 and its pointer width shall live in the shared parameter file.
REQ-035 The FIFO shall be a sub-module rd_capture_fifo, instantiated only under RD_CAPTURE_FIFO_EN.

Verification
REQ-036 page_mod=0, bur_len=4, cas_lat=2, do_reada at T0, DQ=A0..A3 from T0+2 -> 4 beats A0..A3, first rd_valid at T0+3, rd_last on A3.
REQ-037 Same with cas_lat=3 -> first beat at T0+4; cas_lat=5 behaves as 3.
REQ-038 page_mod=1, do_reada at T0, do_preacharge at T0+10, cas_lat=2 -> exactly 10 beats, no rd_last, rd_busy low by T0+13.
REQ-039 bur_len=8, second do_reada at T0+3 -> 3 beats of burst 1 then 8 of burst 2; rd_last only on final beat.
REQ-040 FIFO build: rd_ready=0, two bur_len=8 reads -> 8 entries held, 8 beats dropped, rd_ovf=1; then rd_ready=1 drains 8 beats in order.
REQ-041 Reset asserted at T0+3 of a bur_len=8 read -> all outputs 0 next cycle; no rd_valid after release.

Source files
------------

// File: rtl/rd_data_capture_pkg.sv
// Shared sizes and helpers for the SDRAM read-data capture path.
// The optional capture FIFO is enabled by defining RD_CAPTURE_FIFO_EN.
package rd_data_capture_pkg;

  localparam int DATA_SIZE  = 32;
  localparam int BURST_SIZE = 4;
  localparam int CAS_SIZE   = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_PTR_W = 3;
  localparam int DL_LEN     = 4;

  // One expect bit in flight; long_lat selects the 3-stage tap instead of 2.
  typedef struct packed {
    logic vld;
    logic last;
    logic long_lat;
  } dl_stage_t;

  function automatic logic [BURST_SIZE-1:0] burst_beats(input logic [BURST_SIZE-1:0] bl);
    case (bl)
      BURST_SIZE'(1), BURST_SIZE'(2), BURST_SIZE'(4), BURST_SIZE'(8): burst_beats = bl;
      default: burst_beats = BURST_SIZE'(1);
    endcase
  endfunction

endpackage

// File: rtl/rd_data_capture_fifo.sv
// 8-entry capture FIFO holding {last, data}; drops and flags overflow when full.
// Only instantiated when RD_CAPTURE_FIFO_EN is defined.
module rd_capture_fifo
  import rd_data_capture_pkg::*;
#(
  parameter int W = DATA_SIZE + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);

  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wptr_q, rptr_q;
  logic [FIFO_PTR_W:0]   cnt_q;
  logic                  ovf_q;
  logic                  full, empty, do_pop, do_push, drop;

  assign full    = (cnt_q == (FIFO_PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty;
  // A pop in the same cycle frees the slot, so push-on-full is legal then.
  assign do_push = push_i & (~full | do_pop);
  assign drop    = push_i & full & ~do_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign valid_o = ~empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q];
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/rd_data_capture.sv
// SDRAM read-data capture: tracks expected beats through a CAS-latency delay line
// and captures registered DQ on alignment. Define RD_CAPTURE_FIFO_EN for buffering.
module rd_data_capture
  import rd_data_capture_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int burst_size = BURST_SIZE,
  parameter int cas_size   = CAS_SIZE
) (
  input  logic                  clk0,
  input  logic                  reset,
  input  logic                  page_mod,
  input  logic                  do_reada,
  input  logic                  do_writea1,
  input  logic                  do_preacharge,
  input  logic                  do_refresh,
  input  logic [burst_size-1:0] bur_len,
  input  logic [cas_size-1:0]   cas_lat,
  input  logic [data_size-1:0]  sdr_dq_in,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [data_size-1:0]  rd_data,
  output logic                  rd_last,
  output logic                  rd_busy,
  output logic                  rd_ovf
);

  logic [burst_size-1:0] cnt_q, cnt_d, beats;
  logic                  win_q, win_d;
  logic                  lat_long_q, lat_long_d;
  logic                  term;
  dl_stage_t             issue;
  dl_stage_t             dl_q [DL_LEN];
  logic [data_size-1:0]  dq_p0_q;
  logic                  cap_vld, cap_last, dl_busy;

  // Issue stage: one expect bit per cycle; a new read always overrides.
  always_comb begin
    term       = do_writea1 | do_preacharge | do_refresh;
    beats      = burst_beats(bur_len);
    cnt_d      = cnt_q;
    win_d      = win_q;
    lat_long_d = lat_long_q;
    issue      = '0;
    if (do_reada) begin
      lat_long_d = (cas_lat != cas_size'(2));
      issue.vld  = 1'b1;
      if (page_mod) begin
        win_d = 1'b1;
        cnt_d = '0;
      end else begin
        win_d      = 1'b0;
        cnt_d      = beats - burst_size'(1);
        issue.last = (beats == burst_size'(1));
      end
    end else if (win_q) begin
      if (term) win_d = 1'b0;
      else      issue.vld = 1'b1;
    end else if (cnt_q != '0) begin
      issue.vld  = 1'b1;
      issue.last = (cnt_q == burst_size'(1));
      cnt_d      = cnt_q - burst_size'(1);
    end
    issue.long_lat = lat_long_d;
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      win_q      <= 1'b0;
      lat_long_q <= 1'b0;
      dq_p0_q    <= '0;
      for (int i = 0; i < DL_LEN; i++) dl_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      lat_long_q <= lat_long_d;
      dq_p0_q    <= sdr_dq_in;
      dl_q[0]    <= issue;
      dl_q[1]    <= dl_q[0];
      dl_q[2]    <= dl_q[1];
      // Short-latency bits are consumed at stage 2 and do not travel further.
      dl_q[3]    <= dl_q[2].long_lat ? dl_q[2] : '0;
    end
  end

  // Capture stage: delayed expect bit aligned with registered DQ.
  always_comb begin
    cap_vld  = (dl_q[2].vld & ~dl_q[2].long_lat) | dl_q[3].vld;
    cap_last = dl_q[3].vld ? dl_q[3].last : (dl_q[2].vld & ~dl_q[2].long_lat & dl_q[2].last);
    dl_busy  = dl_q[0].vld | dl_q[1].vld | dl_q[2].vld | dl_q[3].vld;
  end

`ifdef RD_CAPTURE_FIFO_EN
  logic [data_size:0] fifo_data;
  logic               fifo_vld;

  rd_capture_fifo #(
    .W(data_size + 1)
  ) u_fifo (
    .clk_i  (clk0),
    .rst_i  (reset),
    .push_i (cap_vld),
    .data_i ({cap_last, dq_p0_q}),
    .pop_i  (rd_ready),
    .valid_o(fifo_vld),
    .data_o (fifo_data),
    .ovf_o  (rd_ovf)
  );

  assign rd_valid = fifo_vld;
  assign rd_data  = fifo_data[data_size-1:0];
  assign rd_last  = fifo_data[data_size];
  assign rd_busy  = (cnt_q != '0) | win_q | dl_busy | fifo_vld;
`else
  logic unused_rd_ready;
  assign unused_rd_ready = rd_ready;

  assign rd_valid = cap_vld;
  assign rd_data  = cap_vld ? dq_p0_q : '0;
  assign rd_last  = cap_vld & cap_last;
  assign rd_busy  = (cnt_q != '0) | win_q | dl_busy;
  assign rd_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_rd_data_capture.sv
// Scoreboard bench for rd_data_capture: a read-schedule model predicts each beat
// (arrival cycle, source DQ cycle, last flag); a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_rd_data_capture;

`ifdef RD_CAPTURE_FIFO_EN
  localparam int FIFO_LAT = 1;
  localparam bit HAS_FIFO = 1'b1;
`else
  localparam int FIFO_LAT = 0;
  localparam bit HAS_FIFO = 1'b0;
`endif

  logic        clk0 = 1'b0;
  logic        reset = 1'b1;
  logic        page_mod = 1'b0, do_reada = 1'b0;
  logic        do_writea1 = 1'b0, do_preacharge = 1'b0, do_refresh = 1'b0;
  logic [3:0]  bur_len = 4'd0;
  logic [2:0]  cas_lat = 3'd2;
  logic [31:0] sdr_dq_in = '0;
  logic        rd_ready = 1'b1;
  logic        rd_valid, rd_last, rd_busy, rd_ovf;
  logic [31:0] rd_data;

  rd_data_capture dut (
    .clk0(clk0), .reset(reset), .page_mod(page_mod), .do_reada(do_reada),
    .do_writea1(do_writea1), .do_preacharge(do_preacharge), .do_refresh(do_refresh),
    .bur_len(bur_len), .cas_lat(cas_lat), .sdr_dq_in(sdr_dq_in), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
    .rd_ovf(rd_ovf)
  );

  always #5 clk0 = ~clk0;

  int cyc = 0;
  always @(posedge clk0) cyc <= cyc + 1;

  typedef struct {
    int   out;
    int   src;
    logic last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] dq_hist [int];
  int          total = 0, bad = 0;

  // Model of the current read as a schedule: start cycle, length, latency.
  bit rd_act = 0, rd_page = 0;
  int rd_start = 0, rd_len = 0, rd_lat = 2;
  bit strict = 1, cap_en = 0, skip_ovf = 0, exp_ovf = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic void model_step(bit rda, bit pm, bit term, int bl, int cl, int c);
    bit    beat = 0, last = 0;
    beat_t b;
    if (rda) begin
      rd_act   = 1;
      rd_page  = pm;
      rd_start = c;
      rd_len   = (bl == 1 || bl == 2 || bl == 4 || bl == 8) ? bl : 1;
      rd_lat   = (cl == 2) ? 2 : 3;
    end else if (rd_act && rd_page && term) begin
      rd_act = 0;
    end
    if (rd_act) begin
      if (rd_page) beat = 1;
      else if (c - rd_start < rd_len) begin
        beat = 1;
        last = (c - rd_start == rd_len - 1);
      end else rd_act = 0;
    end
    if (beat) begin
      if (cap_en && exp_q.size() >= 8) exp_ovf = 1;
      else begin
        b.out  = c + rd_lat + 1 + FIFO_LAT;
        b.src  = c + rd_lat;
        b.last = last;
        exp_q.push_back(b);
      end
    end
  endfunction

  task automatic cyc_drive(bit rda, bit pm, int term, int bl, int cl, bit rdy);
    bit busy_exp;
    @(posedge clk0); #1;
    busy_exp = (rd_act && (rd_page || rd_start + rd_len > cyc)) || (exp_q.size() > 0);
    check("busy", rd_busy, busy_exp);
    if (!skip_ovf) check("ovf_clear", rd_ovf, 0);
    do_reada      = rda;
    page_mod      = pm;
    do_preacharge = (term == 1);
    do_writea1    = (term == 2);
    do_refresh    = (term == 3);
    bur_len       = bl[3:0];
    cas_lat       = cl[2:0];
    rd_ready      = rdy;
    sdr_dq_in     = $urandom;
    dq_hist[cyc]  = sdr_dq_in;
    model_step(rda, pm, term != 0, bl, cl, cyc);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc_drive(0, 0, 0, 0, 2, 1);
  endtask

  task automatic do_reset();
    @(posedge clk0); #1;
    reset = 1;
    do_reada = 0; do_preacharge = 0; do_writea1 = 0; do_refresh = 0;
    exp_q.delete();
    rd_act  = 0;
    exp_ovf = 0;
    #1;
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_last", rd_last, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_ovf", rd_ovf, 0);
    repeat (2) @(posedge clk0);
    #1 reset = 0;
  endtask

  always @(negedge clk0) begin
    if (!reset) begin
      while (strict && exp_q.size() > 0 && exp_q[0].out < cyc) begin
        check("missed_beat", exp_q[0].out, cyc);
        void'(exp_q.pop_front());
      end
      if (rd_valid && (rd_ready || !HAS_FIFO)) begin
        if (exp_q.size() == 0) check("unexpected_beat", rd_data, 0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          if (strict) check("beat_cycle", cyc, b.out);
          check("beat_data", rd_data, dq_hist[b.src]);
          check("beat_last", rd_last, b.last);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl, cl, term;
    bit rda, pm;
    do_reset();

    cyc_drive(1, 0, 0, 4, 2, 1); idle(10);   // cas 2, burst 4
    cyc_drive(1, 0, 0, 4, 3, 1); idle(10);   // cas 3
    cyc_drive(1, 0, 0, 4, 5, 1); idle(10);   // cas 5 behaves as 3
    cyc_drive(1, 0, 0, 6, 2, 1); idle(8);    // illegal length -> single beat

    // Page burst closed by precharge ten cycles later.
    cyc_drive(1, 1, 0, 0, 2, 1);
    idle(9);
    cyc_drive(0, 0, 1, 0, 2, 1);
    idle(2);
    @(posedge clk0); #1;
    check("page_busy_low", rd_busy, 0);

    // Read interrupt: second burst of 8 three cycles in, cas change mid-burst ignored.
    cyc_drive(1, 0, 0, 8, 2, 1); idle(2);
    cyc_drive(1, 0, 0, 8, 2, 1);
    for (int i = 0; i < 14; i++) cyc_drive(0, 0, 0, 0, 3, 1);

    // Terminator and read in the same cycle: the read wins.
    cyc_drive(1, 1, 0, 0, 3, 1); idle(3);
    cyc_drive(1, 0, 2, 2, 3, 1); idle(10);

    // Reset three cycles into a burst of 8 discards everything in flight.
    cyc_drive(1, 0, 0, 8, 2, 1); idle(2);
    do_reset();
    idle(15);

`ifdef RD_CAPTURE_FIFO_EN
    cap_en = 1; skip_ovf = 1;
    cyc_drive(1, 0, 0, 8, 2, 0);
    for (int i = 0; i < 7; i++) cyc_drive(0, 0, 0, 0, 2, 0);
    cyc_drive(1, 0, 0, 8, 2, 0);
    for (int i = 0; i < 15; i++) cyc_drive(0, 0, 0, 0, 2, 0);
    check("fifo_ovf", rd_ovf, exp_ovf);
    check("fifo_held", exp_q.size(), 8);
    strict = 0;
    for (int i = 0; i < 12; i++) cyc_drive(0, 0, 0, 0, 2, 1);
    check("fifo_drained", exp_q.size(), 0);
    cap_en = 0;
    do_reset();
    strict = 1; skip_ovf = 0;
`endif

    for (int i = 0; i < 500; i++) begin
      rda  = ($urandom_range(0, 5) == 0);
      pm   = ($urandom_range(0, 2) == 0);
      term = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      bl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : (1 << $urandom_range(0, 3));
      cl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(2, 3);
      // Keep latency class stable while beats are in flight so arrivals cannot collide.
      if (rda && (rd_act || exp_q.size() > 0)) cl = rd_lat;
      cyc_drive(rda, pm, term, bl, cl, HAS_FIFO ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    cyc_drive(0, 0, 1, 0, 2, 1);
    idle(20);
    check("final_drain", exp_q.size(), 0);
    check("final_busy", rd_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
